// File: rtl/sync_period_gen_if.sv
// Software-facing bundle for sync_period_gen: period word and arm level in, pulse/status out.
// ext_sync exists only when SYNC_PERIOD_GEN_EXT_RESYNC_EN is defined.
interface sync_period_gen_if #(
  parameter int PERIOD_W = 32,
  parameter int CNT_W    = 32
);
  logic [PERIOD_W-1:0] period_in;
  logic                arm;
`ifdef SYNC_PERIOD_GEN_EXT_RESYNC_EN
  logic                ext_sync;
`endif
  logic                sync_out;
  logic                running;
  logic [CNT_W-1:0]    sync_count;
  logic                period_err;

`ifdef SYNC_PERIOD_GEN_EXT_RESYNC_EN
  modport master (output period_in, arm, ext_sync,
                  input  sync_out, running, sync_count, period_err);
  modport slave  (input  period_in, arm, ext_sync,
                  output sync_out, running, sync_count, period_err);
`else
  modport master (output period_in, arm,
                  input  sync_out, running, sync_count, period_err);
  modport slave  (input  period_in, arm,
                  output sync_out, running, sync_count, period_err);
`endif
endinterface

// File: rtl/sync_period_gen.sv
// Periodic single-cycle sync pulse every period_in user_clk cycles; first pulse 1 cycle after arm edge.
// No backpressure; period changes apply only at period boundaries. SYNC_PERIOD_GEN_EXT_RESYNC_EN adds ext_sync restart.
module sync_period_gen #(
  parameter int PERIOD_W   = 32,
  parameter int CNT_W      = 32,
  parameter int MIN_PERIOD = 2
) (
  input  logic              user_clk,
  input  logic              user_rst,
  sync_period_gen_if.slave  bus
);

  localparam logic [0:0] ST_IDLE = 1'b0;
  localparam logic [0:0] ST_RUN  = 1'b1;

  logic [0:0]          state;
  logic [PERIOD_W-1:0] cnt;
  logic [PERIOD_W-1:0] active_period;
  logic                arm_q;
  logic                arm_edge;
  logic                restart;
  logic                period_ok;
  logic                terminal;
  logic                sync_q;
  logic [CNT_W-1:0]    count_q;
  logic                err_q;

  assign arm_edge  = bus.arm & ~arm_q;
  assign period_ok = bus.period_in >= PERIOD_W'(MIN_PERIOD);
  assign terminal  = (state == ST_RUN) && (cnt == '0);

`ifdef SYNC_PERIOD_GEN_EXT_RESYNC_EN
  logic ext_q;
  logic ext_q2;
  logic ext_edge;

  // ext_sync gets one register stage before edge detection, so it restarts one cycle later than arm.
  assign ext_edge = ext_q & ~ext_q2;
  assign restart  = arm_edge | (ext_edge && (state == ST_RUN));

  always_ff @(posedge user_clk) begin
    if (user_rst) begin
      ext_q  <= 1'b0;
      ext_q2 <= 1'b0;
    end else begin
      ext_q  <= bus.ext_sync;
      ext_q2 <= ext_q;
    end
  end
`else
  assign restart = arm_edge;
`endif

  always_ff @(posedge user_clk) begin
    if (user_rst) begin
      state         <= ST_IDLE;
      cnt           <= '0;
      active_period <= '0;
      arm_q         <= 1'b0;
      sync_q        <= 1'b0;
      count_q       <= '0;
      err_q         <= 1'b0;
    end else begin
      arm_q  <= bus.arm;
      sync_q <= 1'b0;
      // A restart overrides a coincident terminal reload so only one pulse is emitted.
      if (restart) begin
        if (period_ok) begin
          active_period <= bus.period_in;
          cnt           <= bus.period_in - PERIOD_W'(1);
          sync_q        <= 1'b1;
          count_q       <= count_q + CNT_W'(1);
          err_q         <= 1'b0;
          state         <= ST_RUN;
        end else begin
          err_q <= 1'b1;
          state <= ST_IDLE;
        end
      end else if (terminal) begin
        if (period_ok) begin
          active_period <= bus.period_in;
          cnt           <= bus.period_in - PERIOD_W'(1);
          sync_q        <= 1'b1;
          count_q       <= count_q + CNT_W'(1);
        end else begin
          err_q <= 1'b1;
          state <= ST_IDLE;
        end
      end else if (state == ST_RUN) begin
        cnt <= cnt - PERIOD_W'(1);
      end
    end
  end

  assign bus.sync_out   = sync_q;
  assign bus.running    = (state == ST_RUN);
  assign bus.sync_count = count_q;
  assign bus.period_err = err_q;

  // The down-counter must always sit inside the period that was loaded with it.
  cnt_in_period: assert property (@(posedge user_clk) disable iff (user_rst)
    (state == ST_RUN) |-> (cnt < active_period));

endmodule

// File: tb/tb_sync_period_gen.sv
// Scoreboard bench for sync_period_gen: a pulse-schedule reference model predicts every output cycle.
module tb_sync_period_gen;

  localparam int PERIOD_W   = 32;
  localparam int CNT_W      = 4;
  localparam int MIN_PERIOD = 2;

  logic user_clk = 1'b0;
  logic user_rst = 1'b1;
  always #5 user_clk = ~user_clk;

  sync_period_gen_if #(.PERIOD_W(PERIOD_W), .CNT_W(CNT_W)) bus ();

  sync_period_gen #(.PERIOD_W(PERIOD_W), .CNT_W(CNT_W), .MIN_PERIOD(MIN_PERIOD)) dut (
    .user_clk (user_clk),
    .user_rst (user_rst),
    .bus      (bus)
  );

  typedef struct packed {
    logic             sync;
    logic             run;
    logic [CNT_W-1:0] cnt;
    logic             err;
  } exp_t;

  exp_t exp_q[$];
  int   vectors     = 0;
  int   miscompares = 0;

  // Reference model: absolute cycle index of the next scheduled pulse, not a down-counter.
  longint t          = 0;
  longint next_pulse = 0;
  logic   m_run      = 1'b0;
  int     m_cnt      = 0;
  logic   m_err      = 1'b0;
  logic   m_prev_arm = 1'b0;
  logic   m_ext1     = 1'b0;
  logic   m_ext2     = 1'b0;
  logic   m_last_sync = 1'b0;

  logic   cur_arm = 1'b0;
  int unsigned cur_per = 0;
  logic   cur_ext = 1'b0;

  task automatic model_step(input logic a, input int unsigned p, input logic r, input logic e);
    logic restart;
    logic legal;
    exp_t x;
    t++;
    m_last_sync = 1'b0;
    if (r) begin
      m_run = 1'b0; m_cnt = 0; m_err = 1'b0;
      m_prev_arm = 1'b0; m_ext1 = 1'b0; m_ext2 = 1'b0;
    end else begin
      restart = a && !m_prev_arm;
`ifdef SYNC_PERIOD_GEN_EXT_RESYNC_EN
      if (m_run && m_ext1 && !m_ext2) restart = 1'b1;
      m_ext2 = m_ext1;
      m_ext1 = e;
`endif
      m_prev_arm = a;
      legal = (p >= MIN_PERIOD);
      if (restart || (m_run && t == next_pulse)) begin
        if (legal) begin
          m_run = 1'b1;
          next_pulse = t + longint'(p);
          m_last_sync = 1'b1;
          m_cnt = (m_cnt + 1) % (1 << CNT_W);
          if (restart) m_err = 1'b0;
        end else begin
          m_run = 1'b0;
          m_err = 1'b1;
        end
      end
    end
    x.sync = m_last_sync;
    x.run  = m_run;
    x.cnt  = CNT_W'(m_cnt);
    x.err  = m_err;
    exp_q.push_back(x);
  endtask

  task automatic drive(input logic a, input int unsigned p, input logic r, input logic e);
    @(negedge user_clk);
    user_rst      = r;
    bus.arm       = a;
    bus.period_in = p;
`ifdef SYNC_PERIOD_GEN_EXT_RESYNC_EN
    bus.ext_sync  = e;
`endif
    cur_arm = a; cur_per = p; cur_ext = e;
    model_step(a, p, r, e);
  endtask

  task automatic hold(input int n);
    for (int i = 0; i < n; i++) drive(cur_arm, cur_per, 1'b0, cur_ext);
  endtask

  task automatic run_until_pulse(input int maxc);
    for (int i = 0; i < maxc; i++) begin
      drive(cur_arm, cur_per, 1'b0, cur_ext);
      if (m_last_sync) break;
    end
  endtask

  // Monitor: the DUT presents its registered outputs every cycle, checked 1 time unit after the edge.
  initial begin
    exp_t e;
    forever begin
      @(posedge user_clk);
      #1;
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        vectors++;
        if (bus.sync_out !== e.sync || bus.running !== e.run ||
            bus.sync_count !== e.cnt || bus.period_err !== e.err) begin
          miscompares++;
          $display("FAIL outputs @%0t: got sync=%0b run=%0b cnt=%0d err=%0b, want sync=%0b run=%0b cnt=%0d err=%0b",
                   $time, bus.sync_out, bus.running, bus.sync_count, bus.period_err,
                   e.sync, e.run, e.cnt, e.err);
        end
      end
    end
  end

  initial begin
    bus.arm       = 1'b0;
    bus.period_in = '0;
`ifdef SYNC_PERIOD_GEN_EXT_RESYNC_EN
    bus.ext_sync  = 1'b0;
`endif
    // Reset state.
    repeat (3) drive(1'b0, 0, 1'b1, 1'b0);
    drive(1'b0, 8, 1'b0, 1'b0);

    // Basic spacing, then a period change three cycles after a pulse.
    drive(1'b1, 8, 1'b0, 1'b0);
    hold(34);
    run_until_pulse(10);
    hold(3);
    drive(1'b1, 5, 1'b0, 1'b0);
    hold(20);

    // Illegal arm from idle, then a legal re-arm.
    drive(1'b0, 5, 1'b1, 1'b0);
    drive(1'b0, 1, 1'b0, 1'b0);
    drive(1'b1, 1, 1'b0, 1'b0);
    hold(3);
    drive(1'b0, 4, 1'b0, 1'b0);
    drive(1'b1, 4, 1'b0, 1'b0);
    hold(6);

    // Illegal reload while running at period 6.
    drive(1'b0, 6, 1'b0, 1'b0);
    drive(1'b1, 6, 1'b0, 1'b0);
    run_until_pulse(10);
    drive(1'b1, 0, 1'b0, 1'b0);
    hold(12);

    // Restart two cycles after a pulse, then reset mid-period.
    drive(1'b0, 10, 1'b0, 1'b0);
    drive(1'b1, 10, 1'b0, 1'b0);
    run_until_pulse(12);
    drive(1'b0, 10, 1'b0, 1'b0);
    drive(1'b1, 10, 1'b0, 1'b0);
    hold(24);
    drive(1'b0, 10, 1'b1, 1'b0);
    hold(15);

    // Counter wrap with the narrow sync_count.
    drive(1'b1, 2, 1'b0, 1'b0);
    hold(40);

`ifdef SYNC_PERIOD_GEN_EXT_RESYNC_EN
    drive(1'b0, 10, 1'b0, 1'b0);
    drive(1'b1, 10, 1'b0, 1'b0);
    run_until_pulse(12);
    hold(2);
    drive(1'b1, 10, 1'b0, 1'b1);
    hold(25);
    drive(1'b0, 10, 1'b0, 1'b0);
    drive(1'b1, 10, 1'b0, 1'b1);
    hold(15);
`endif

    // Randomized traffic.
    for (int i = 0; i < 1500; i++) begin
      logic a, r, e;
      int unsigned p;
      a = cur_arm; p = cur_per; e = cur_ext; r = 1'b0;
      if ($urandom_range(0, 29) == 0) a = ~a;
      if ($urandom_range(0, 19) == 0)
        p = ($urandom_range(0, 9) == 0) ? $urandom_range(0, 1) : $urandom_range(2, 12);
      if ($urandom_range(0, 24) == 0) e = ~e;
      if ($urandom_range(0, 299) == 0) r = 1'b1;
      drive(a, p, r, e);
    end

    for (int i = 0; i < 5 && exp_q.size() != 0; i++) @(negedge user_clk);
    if (exp_q.size() != 0) begin
      miscompares++;
      $display("FAIL drain: %0d expected cycles never observed, want 0", exp_q.size());
    end
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/sync_period_gen.md
Name: sync_period_gen

Overview:
- Periodic sync-pulse generator in the user_clk domain.
- Consumes the 32-bit sync period word that the software-writable sync-period register delivers on its user_data_out.
- Produces a single-cycle sync pulse every N user_clk cycles for the downstream DSP chain (FFT/accumulator sync inputs).
- Software arms it with a control bit. Period changes take effect only at a period boundary, so pulse spacing never glitches.

Parameters:
- PERIOD_W, 32, width of period_in and of the internal down-counter.
- CNT_W, 32, width of the sync_count pulse counter.
- MIN_PERIOD, 2, smallest legal period; any value below it is illegal.

Ports:
- user_clk  in  1  block clock; all logic is rising-edge.
- user_rst  in  1  synchronous, active-high reset.
- period_in  in  PERIOD_W  requested period in user_clk cycles; driven by the sync-period register user_data_out.
- arm  in  1  arm/restart request; level from a software register bit; only its rising edge acts.
- sync_out  out  1  registered single-cycle sync pulse.
- running  out  1  high while in RUN.
- sync_count  out  CNT_W  number of pulses emitted since reset.
- period_err  out  1  sticky flag: arm or reload saw an illegal period.

Behaviour:
- Reset:
  - Reset is synchronous and active-high on user_rst; clock is user_clk.
  - Reset values: sync_out=0, running=0, sync_count=0, period_err=0, state=IDLE, counter=0, active_period=0, arm_q=0.
  - Reset wins over every other event in the same cycle, including mid-period. No pulse is emitted on the reset cycle or on the following cycle.
- Edge detect:
  - arm_q <= arm every cycle.
  - arm_edge = arm & ~arm_q.
- States: IDLE, RUN.
- IDLE:
  - On arm_edge with period_in >= MIN_PERIOD: active_period <= period_in, cnt <= active_period-1 (computed from period_in), sync_out <= 1, period_err <= 0, go to RUN.
  - Latency: sync_out is high in the cycle immediately after the edge that samples arm=1.
  - On arm_edge with period_in < MIN_PERIOD: stay in IDLE, period_err <= 1, no pulse.
- RUN:
  - cnt decrements each cycle.
  - When cnt==0 (terminal), reload active_period from period_in.
    - If the new value >= MIN_PERIOD: cnt <= new-1 and sync_out <= 1. Pulse spacing is exactly active_period cycles (rising-edge to rising-edge).
    - If the new value < MIN_PERIOD: no pulse, period_err <= 1, go to IDLE, running <= 0.
  - sync_out is 0 in every non-terminal cycle.
  - period_in changes mid-period are ignored until the next terminal cycle.
  - arm_edge in RUN (restart): identical to the IDLE arm action. The counter restarts and a pulse is emitted next cycle even if a terminal count coincides; only one pulse is emitted. This takes precedence over the terminal reload.
  - Deasserting arm does not stop the generator; only reset or an illegal reload does.
- running: registered, equals (state==RUN).
- sync_count:
  - Increments by 1 in the same cycle sync_out is registered high.
  - Wraps from 2^CNT_W-1 to 0 with no flag.
- period_err:
  - Sticky.
  - Cleared only by reset or by a successful arm.

Optional Feature:
- Macro: SYNC_PERIOD_GEN_EXT_RESYNC_EN.
- Defined:
  - Adds input port ext_sync (1 bit), registered once internally.
  - A rising edge of the registered ext_sync while in RUN acts exactly like a RUN-state arm_edge (counter restart, one pulse next cycle, reload from period_in).
  - It is ignored in IDLE.
  - If arm_edge and ext_sync edge occur in the same cycle, a single restart results.
- Undefined:
  - Port ext_sync is absent.
  - Behaviour is exactly as above.

Test Plan:
- Basic spacing: reset, period_in=8, raise arm → first sync_out 1 cycle after arm is sampled, then pulses every 8 cycles. After 5 pulses, sync_count=5 and running=1.
- Period change at boundary: in RUN with period 8, set period_in=5 three cycles after a pulse → the next pulse is still 8 cycles later, then spacing is 5.
- Illegal period: period_in=1, arm edge → no pulse, running=0, period_err=1. Then period_in=4, new arm edge → pulse next cycle, period_err=0.
- Illegal reload: RUN with period 6, set period_in=0 → at the terminal cycle no pulse, running drops, period_err=1, sync_count frozen.
- Restart and reset: arm edge 2 cycles after a pulse (period 10) → pulse next cycle and 10-cycle spacing from there. Assert user_rst mid-period → all outputs 0 the following cycle and no pulses until re-armed.
- Wrap (CNT_W=4 build): emit 17 pulses with period 2 → sync_count reads 1. With SYNC_PERIOD_GEN_EXT_RESYNC_EN, an ext_sync edge 3 cycles into a period-10 run produces a pulse 2 cycles after the edge (1 sync register plus 1 output register), then 10-cycle spacing.
